// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for an 8-digit seven-segment display.
// Snapshots a 32-bit value once per frame and steps through digits 0..7.
// Each digit slot begins with a blanking interval, then lights that digit's anode.
// All outputs are registered. They are computed from the next-state values, so the
// outputs stay aligned with the registered state.
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module seg7_scan_ctrl #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] val,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [2:0]  digit_sel,
    output logic        frame_tick
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    localparam logic [23:0] PRESC_LAST = 24'(REFRESH_DIV - 1);
    localparam logic [23:0] BLANK_LAST = 24'(BLANK_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [23:0] presc_q, presc_d;
    logic [2:0]  digit_q, digit_d;
    logic [31:0] shadow_q, shadow_d;
    logic        frame_tick_q, frame_tick_d;
    logic [7:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;

    // Active-low hex decode; bit order is {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // upper_zero[k] is set when shadow nibbles k..7 are all zero.
    logic [7:0] upper_zero;
    for (genvar gi = 0; gi < 8; gi++) begin : g_upper_zero
        assign upper_zero[gi] = (shadow_d[31:4*gi] == '0);
    end
`endif

    // Next-state logic: the scan FSM, the prescaler, digit stepping and the frame reload.
    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        digit_d      = digit_q;
        shadow_d     = shadow_q;
        frame_tick_d = 1'b0;
        if (!en) begin
            // A disabled controller idles and keeps tracking val. If en falls on a
            // reload cycle, the shadow still loads but frame_tick stays low.
            state_d  = ST_IDLE;
            presc_d  = '0;
            digit_d  = '0;
            shadow_d = val;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_BLANK;
                    presc_d  = '0;
                    digit_d  = '0;
                    shadow_d = val;
                end
                ST_BLANK: begin
                    presc_d = presc_q + 24'd1;
                    if (presc_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (presc_q == PRESC_LAST) begin
                        // Step digit_sel as BLANK is entered, so it settles before an anode drops.
                        state_d = ST_BLANK;
                        presc_d = '0;
                        digit_d = digit_q + 3'd1;
                        if (digit_q == 3'd7) begin
                            shadow_d     = val;
                            frame_tick_d = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 24'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from the next state, so the registered outputs line up with the registered state.
    always_comb begin
        logic lit;
        an_d  = 8'hFF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        lit   = (state_d == ST_SHOW);
`ifdef LEADING_ZERO_BLANK_EN
        if ((digit_d != 3'd0) && upper_zero[digit_d] && !dp_mask[digit_d]) begin
            lit = 1'b0;
        end
`endif
        if (lit) begin
            an_d  = ~(8'h01 << digit_d);
            seg_d = hex_decode(shadow_d[{digit_d, 2'b00} +: 4]);
            dp_d  = ~dp_mask[digit_d];
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            digit_q      <= '0;
            shadow_q     <= '0;
            frame_tick_q <= 1'b0;
            an_q         <= 8'hFF;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            digit_q      <= digit_d;
            shadow_q     <= shadow_d;
            frame_tick_q <= frame_tick_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign digit_sel  = digit_q;
    assign frame_tick = frame_tick_q;

endmodule
